// File: rtl/bid_collector.sv
// Sequential front end for the auction block: collects one bid per bidder over a
// valid/ready port, then presents the packed bid bus until the consumer acknowledges.
module bid_collector #(
    parameter int N = 3,
    parameter int W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_id,
    input  logic [W-1:0]          in_bid,
    input  logic                  close,
    output logic [(2**N)*W-1:0]   bid,
    output logic                  bid_valid,
    input  logic                  bid_ack,
    output logic [2**N-1:0]       received,
    output logic                  dup_err
);

    localparam int S = 2**N;

    // Handshake: a bid transfers on a rising edge where in_valid && in_ready.
    // in_ready is a pure function of state and never looks at in_valid.
    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [S*W-1:0]     bid_q, bid_d;
    logic [S-1:0]       received_q, received_d;
    logic               dup_err_q, dup_err_d;
    logic               in_ready_q, in_ready_d;
    logic               bid_valid_q, bid_valid_d;

    always_comb begin
        state_d    = state_q;
        bid_d      = bid_q;
        received_d = received_q;
        dup_err_d  = 1'b0;

        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    if (received_q[in_id]) begin
                        dup_err_d = 1'b1;
                    end else begin
                        bid_d[int'(in_id)*W +: W] = in_bid;
                        received_d[in_id]         = 1'b1;
                    end
                end
                // received_d is only all-ones when this edge's bid filled the last slot
                if (close || (&received_d)) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bid_ack) begin
                    state_d    = COLLECT;
                    bid_d      = '0;
                    received_d = '0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        in_ready_d  = (state_d == COLLECT);
        bid_valid_d = (state_d == PRESENT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            bid_q       <= '0;
            received_q  <= '0;
            dup_err_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            bid_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bid_q       <= bid_d;
            received_q  <= received_d;
            dup_err_q   <= dup_err_d;
            in_ready_q  <= in_ready_d;
            bid_valid_q <= bid_valid_d;
        end
    end

    assign bid       = bid_q;
    assign received  = received_q;
    assign dup_err   = dup_err_q;
    assign in_ready  = in_ready_q;
    assign bid_valid = bid_valid_q;

endmodule

// File: tb/tb_bid_collector.sv
// Directed, table-driven bench for bid_collector (N=3, W=3): each row drives one
// cycle of inputs and lists the outputs expected just after that edge.
module tb_bid_collector;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_id;
    logic [2:0]  in_bid;
    logic        close;
    logic [23:0] bid;
    logic        bid_valid;
    logic        bid_ack;
    logic [7:0]  received;
    logic        dup_err;

    bid_collector #(.N(3), .W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_id    (in_id),
        .in_bid   (in_bid),
        .close    (close),
        .bid      (bid),
        .bid_valid(bid_valid),
        .bid_ack  (bid_ack),
        .received (received),
        .dup_err  (dup_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [2:0]  id;
        logic [2:0]  b;
        logic        cl;
        logic        ack;
        logic [23:0] e_bid;
        logic [7:0]  e_rcv;
        logic        e_bv;
        logic        e_dup;
        string       nm;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [23:0] pk(input logic [2:0] s0, input logic [2:0] s1,
                                       input logic [2:0] s2, input logic [2:0] s3,
                                       input logic [2:0] s4, input logic [2:0] s5,
                                       input logic [2:0] s6, input logic [2:0] s7);
        return {s7, s6, s5, s4, s3, s2, s1, s0};
    endfunction

    // highest bid wins, lowest index on a tie
    function automatic int winner(input logic [23:0] bus);
        int          w;
        logic [2:0]  best;
        logic [2:0]  s;
        w    = 0;
        best = bus[2:0];
        for (int i = 1; i < 8; i++) begin
            s = bus[i*3 +: 3];
            if (s > best) begin
                best = s;
                w    = i;
            end
        end
        return w;
    endfunction

    task automatic add(input logic v, input logic [2:0] id, input logic [2:0] b,
                       input logic cl, input logic ack, input logic [23:0] e_bid,
                       input logic [7:0] e_rcv, input logic e_bv, input logic e_dup,
                       input string nm);
        vec_t r;
        r.v = v; r.id = id; r.b = b; r.cl = cl; r.ack = ack;
        r.e_bid = e_bid; r.e_rcv = e_rcv; r.e_bv = e_bv; r.e_dup = e_dup; r.nm = nm;
        vq.push_back(r);
    endtask

    task automatic add_full(input string nm);
        logic [2:0]  bv [8];
        logic [23:0] e;
        bv = '{3'd6, 3'd0, 3'd1, 3'd4, 3'd7, 3'd3, 3'd5, 3'd2};
        e  = '0;
        for (int i = 0; i < 8; i++) begin
            e[i*3 +: 3] = bv[i];
            add(1'b1, 3'(i), bv[i], 1'b0, 1'b0, e, 8'((16'd1 << (i + 1)) - 16'd1),
                (i == 7), 1'b0, $sformatf("%s_%0d", nm, i));
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // driver
    task automatic idle();
        in_valid = 1'b0;
        in_id    = 3'd0;
        in_bid   = 3'd0;
        close    = 1'b0;
        bid_ack  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            in_valid = vq[i].v;
            in_id    = vq[i].id;
            in_bid   = vq[i].b;
            close    = vq[i].cl;
            bid_ack  = vq[i].ack;
            tick();
            chk({vq[i].nm, ".bid"},       32'(bid),       32'(vq[i].e_bid));
            chk({vq[i].nm, ".received"},  32'(received),  32'(vq[i].e_rcv));
            chk({vq[i].nm, ".bid_valid"}, 32'(bid_valid), 32'(vq[i].e_bv));
            chk({vq[i].nm, ".in_ready"},  32'(in_ready),  32'(!vq[i].e_bv));
            chk({vq[i].nm, ".dup_err"},   32'(dup_err),   32'(vq[i].e_dup));
        end
        idle();
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".bid"},       32'(bid),       32'h0);
        chk({nm, ".received"},  32'(received),  32'h0);
        chk({nm, ".bid_valid"}, 32'(bid_valid), 32'h0);
        chk({nm, ".in_ready"},  32'(in_ready),  32'h1);
        chk({nm, ".dup_err"},   32'(dup_err),   32'h0);
    endtask

    int a0, a1, b0, b1, c0, c1, d0, d1, e0, e1, f0, f1, g0, g1, h0, h1;

    initial begin
        logic [23:0] clr;
        clr = '0;
        idle();
        rst_n = 1'b0;

        // full round
        a0 = vq.size(); add_full("full"); a1 = vq.size();
        add(0, 0, 0, 0, 1, clr, 8'h00, 0, 0, "full_ack"); b0 = a1; b1 = vq.size();

        // out of order with a duplicate from bidder 3
        c0 = vq.size();
        add(1, 3, 7, 0, 0, pk(0,0,0,7,0,0,0,0), 8'h08, 0, 0, "dup_a");
        add(1, 3, 1, 0, 0, pk(0,0,0,7,0,0,0,0), 8'h08, 0, 1, "dup_b");
        add(1, 0, 1, 0, 0, pk(1,0,0,7,0,0,0,0), 8'h09, 0, 0, "dup_c");
        add(1, 1, 2, 0, 0, pk(1,2,0,7,0,0,0,0), 8'h0B, 0, 0, "dup_d");
        add(1, 2, 3, 0, 0, pk(1,2,3,7,0,0,0,0), 8'h0F, 0, 0, "dup_e");
        add(1, 4, 4, 0, 0, pk(1,2,3,7,4,0,0,0), 8'h1F, 0, 0, "dup_f");
        add(1, 5, 5, 0, 0, pk(1,2,3,7,4,5,0,0), 8'h3F, 0, 0, "dup_g");
        add(1, 6, 6, 0, 0, pk(1,2,3,7,4,5,6,0), 8'h7F, 0, 0, "dup_h");
        add(1, 7, 0, 0, 0, pk(1,2,3,7,4,5,6,0), 8'hFF, 1, 0, "dup_i");
        c1 = vq.size();
        add(0, 0, 0, 0, 1, clr, 8'h00, 0, 0, "dup_ack"); d0 = c1; d1 = vq.size();

        // early close, then inputs ignored while presenting
        e0 = vq.size();
        add(1, 1, 5, 0, 0, pk(0,5,0,0,0,0,0,0), 8'h02, 0, 0, "ec_a");
        add(0, 0, 0, 0, 0, pk(0,5,0,0,0,0,0,0), 8'h02, 0, 0, "ec_idle");
        add(1, 6, 2, 0, 0, pk(0,5,0,0,0,0,2,0), 8'h42, 0, 0, "ec_b");
        add(0, 0, 0, 1, 0, pk(0,5,0,0,0,0,2,0), 8'h42, 1, 0, "ec_close");
        e1 = vq.size();
        add(1, 1, 7, 1, 0, pk(0,5,0,0,0,0,2,0), 8'h42, 1, 0, "pres_ignore");
        add(1, 6, 3, 0, 0, pk(0,5,0,0,0,0,2,0), 8'h42, 1, 0, "pres_ignore2");
        add(0, 0, 0, 0, 1, clr, 8'h00, 0, 0, "ec_ack");
        f0 = e1; f1 = vq.size();

        // simultaneous close + bid, zero-bid close, held ack
        g0 = vq.size();
        add(1, 7, 6, 1, 0, pk(0,0,0,0,0,0,0,6), 8'h80, 1, 0, "sim_close");
        add(0, 0, 0, 0, 1, clr, 8'h00, 0, 0, "sim_ack");
        add(0, 0, 0, 1, 0, clr, 8'h00, 1, 0, "zero_close");
        add(0, 0, 0, 0, 1, clr, 8'h00, 0, 0, "ack_held1");
        add(0, 0, 0, 0, 1, clr, 8'h00, 0, 0, "ack_held2");
        add(0, 0, 0, 0, 1, clr, 8'h00, 0, 0, "ack_held3");
        add(1, 2, 3, 0, 0, pk(0,0,3,0,0,0,0,0), 8'h04, 0, 0, "post_ack_bid");
        add(0, 0, 0, 1, 0, pk(0,0,3,0,0,0,0,0), 8'h04, 1, 0, "post_ack_close");
        add(0, 0, 0, 0, 1, clr, 8'h00, 0, 0, "post_ack_ack");
        g1 = vq.size();

        // partial round to be discarded by reset, then a full round
        h0 = vq.size();
        add(1, 0, 1, 0, 0, pk(1,0,0,0,0,0,0,0), 8'h01, 0, 0, "part_0");
        add(1, 1, 2, 0, 0, pk(1,2,0,0,0,0,0,0), 8'h03, 0, 0, "part_1");
        add(1, 2, 3, 0, 0, pk(1,2,3,0,0,0,0,0), 8'h07, 0, 0, "part_2");
        add(1, 3, 4, 0, 0, pk(1,2,3,4,0,0,0,0), 8'h0F, 0, 0, "part_3");
        h1 = vq.size();
        add_full("refull");
        add(0, 0, 0, 0, 1, clr, 8'h00, 0, 0, "refull_ack");

        // reset state
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("post_reset_idle");

        run(a0, a1);
        chk("full.winner", 32'(winner(bid)), 32'd4);
        chk("full.win_bid", 32'(bid[4*3 +: 3]), 32'd7);
        run(b0, b1);

        run(c0, c1);
        chk("dup.winner", 32'(winner(bid)), 32'd3);
        run(d0, d1);

        run(e0, e1);
        chk("ec.winner", 32'(winner(bid)), 32'd1);
        run(f0, f1);

        run(g0, g1);

        run(h0, h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_reset");
        #2;
        rst_n = 1'b1;
        run(h1, vq.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
